rom_read_arbiter: RTL
=====================

# rom_read_arbiter

Shares one synchronous-read ROM port (rd_en/addr in, data_out registered one cycle later, held while rd_en is low) among N_REQ requesters. Arbitration is round-robin, with a valid/ready request handshake per requester and one valid/ready response channel tagged with the requester index. It sits between the lookup-table ROMs and the blocks that read them, and sustains one read per cycle when the response side is not stalled.

## Interface
- N_REQ, 4, number of requesters (2..16)
- ADDR_WIDTH, 3, ROM address width
- DATA_WIDTH, 9, ROM data width
- ID_WIDTH, $clog2(N_REQ), response tag width
- clk  in  1  clock, all state on rising edge
- rst  in  1  reset, asynchronous, active-high
- req_valid  in  N_REQ  per-requester read request
- req_addr  in  N_REQ*ADDR_WIDTH  request addresses; slice i belongs to requester i
- req_ready  out  N_REQ  one-hot grant; a request is accepted when req_valid[i] && req_ready[i]
- rom_rd_en  out  1  to ROM rd_en
- rom_addr  out  ADDR_WIDTH  to ROM addr
- rom_data  in  DATA_WIDTH  from ROM data_out
- resp_valid  out  1  response available
- resp_ready  in  1  consumer accepts response
- resp_id  out  ID_WIDTH  index of requester that issued the read
- resp_data  out  DATA_WIDTH  read data

## Operation
- State: rr_ptr (last granted index), inflight bit plus inflight_id (ROM output holds an unconsumed read), response register (resp_valid, resp_id, resp_data).
- stall = resp_valid && !resp_ready.
- issue_ok = !(inflight && stall). When issue_ok is high and any req_valid is set, grant the first valid requester at or after rr_ptr+1 (mod N_REQ). Otherwise grant none.
- req_ready, rom_rd_en and rom_addr are combinational from the grant. req_ready is one-hot or zero. rom_rd_en = |req_ready. rom_addr = granted slice, or 0 when there is no grant.
- On grant: rr_ptr <= granted index, inflight <= 1, inflight_id <= granted index.
- Capture: if inflight && !stall, resp_data <= rom_data, resp_id <= inflight_id, resp_valid <= 1. inflight clears unless a new grant happens in the same cycle.
- If resp_valid && resp_ready and there is no capture, resp_valid <= 0.
- While stalled, an inflight read waits in the ROM output register, which the ROM holds because rd_en is low. Data is never dropped.
- Requesters hold req_valid and req_addr stable until accepted. The arbiter does not latch unaccepted requests.
- Responses are returned in grant order.

## Timing
- Reset values: rr_ptr = N_REQ-1, so requester 0 has priority first. inflight = 0, resp_valid = 0, resp_id = 0, resp_data = 0. req_ready = 0, rom_rd_en = 0 and rom_addr = 0 while rst is high.
- Latency: accepted in cycle t, ROM data valid in cycle t+1, resp_valid in cycle t+2 when not stalled.
- Throughput: one grant per cycle while resp_ready stays high.
- Stall with inflight = 0: one more grant is allowed. After that, no grant until the stall clears.
- Stall clears (resp_ready high) with inflight = 1: in that cycle, the response is consumed, the inflight read is captured, and a new grant may issue.
- Only one requester valid: it is granted every eligible cycle regardless of rr_ptr.
- rr_ptr wraps from N_REQ-1 to 0.
- Reset mid-operation: inflight and response are discarded immediately, with no response emitted for them. Arbitration restarts from requester 0.

## Test plan
Bench model: ROM with contents 0→0x1FB, 1→0x101, 2→0x000, 3→0x0FF, 4→0x1FF, N_REQ=4.
- Single read: req_valid=0001, addr0=1, resp_ready=1. Expect req_ready=0001 in cycle t, then resp_valid, resp_id=0 and resp_data=0x101 in cycle t+2.
- Round-robin: all four requests held valid with addrs 0,3,4,2, resp_ready=1. Expect grants 0,1,2,3,0 on consecutive cycles and responses 0x1FB, 0x0FF, 0x1FF, 0x000 back-to-back with matching ids.
- Backpressure: all valid, resp_ready=0 for 5 cycles. Expect exactly 2 grants, then req_ready=0 and resp held stable (id 0, data unchanged). After resp_ready=1, the sequence resumes with no loss or duplication.
- Fairness: requester 2 held valid continuously, requester 0 pulsing valid. Requester 0 is never starved more than one grant.
- Reset mid-stream: assert rst while resp_valid=1 and inflight=1. Outputs go to 0 immediately. After release, first grant goes to requester 0 and no stale response appears.
- Wrap: only requester 3 valid repeatedly, then requesters 3 and 0 both valid. Expect alternation 0,3,0,3.

Source files
------------

// File: rtl/rom_read_arbiter.sv
// Round-robin arbiter sharing one synchronous-read ROM port among N_REQ requesters.
// Responses come back in grant order on one valid/ready channel tagged with the requester index.
module rom_read_arbiter #(
  parameter int unsigned N_REQ      = 4,
  parameter int unsigned ADDR_WIDTH = 3,
  parameter int unsigned DATA_WIDTH = 9,
  parameter int unsigned ID_WIDTH   = $clog2(N_REQ)
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic [N_REQ-1:0]            req_valid,
  input  logic [N_REQ*ADDR_WIDTH-1:0] req_addr,
  output logic [N_REQ-1:0]            req_ready,
  output logic                        rom_rd_en,
  output logic [ADDR_WIDTH-1:0]       rom_addr,
  input  logic [DATA_WIDTH-1:0]       rom_data,
  output logic                        resp_valid,
  input  logic                        resp_ready,
  output logic [ID_WIDTH-1:0]         resp_id,
  output logic [DATA_WIDTH-1:0]       resp_data
);

  if (N_REQ < 2 || N_REQ > 16) begin : g_bad_n_req
    $error("rom_read_arbiter: N_REQ must be within 2..16");
  end
  if (ID_WIDTH < $clog2(N_REQ)) begin : g_bad_id_width
    $error("rom_read_arbiter: ID_WIDTH too narrow for N_REQ");
  end

  logic [ID_WIDTH-1:0]   rr_ptr_q, rr_ptr_d;
  logic                  inflight_q, inflight_d;
  logic [ID_WIDTH-1:0]   inflight_id_q, inflight_id_d;
  logic                  resp_valid_q, resp_valid_d;
  logic [ID_WIDTH-1:0]   resp_id_q, resp_id_d;
  logic [DATA_WIDTH-1:0] resp_data_q, resp_data_d;

  logic                  stall;
  logic                  issue_ok;
  logic                  capture;
  logic                  gnt_valid;
  logic [ID_WIDTH-1:0]   gnt_idx;
  logic [ID_WIDTH-1:0]   cand_idx;

  // (base + off) mod N_REQ without a divider; off never exceeds N_REQ.
  function automatic logic [ID_WIDTH-1:0] wrap_idx(input int unsigned base,
                                                   input int unsigned off);
    int unsigned sum;
    sum = base + off;
    if (sum >= N_REQ) begin
      sum = sum - N_REQ;
    end
    return ID_WIDTH'(sum);
  endfunction

  assign stall    = resp_valid_q && !resp_ready;
  // A read still sitting in the ROM output must not be overwritten while the response is stuck.
  assign issue_ok = !(inflight_q && stall);
  assign capture  = inflight_q && !stall;

  always_comb begin
    gnt_valid = 1'b0;
    gnt_idx   = '0;
    cand_idx  = '0;
    if (!rst && issue_ok) begin
      for (int unsigned off = 1; off <= N_REQ; off++) begin
        cand_idx = wrap_idx(32'(rr_ptr_q), off);
        if (!gnt_valid && req_valid[cand_idx]) begin
          gnt_valid = 1'b1;
          gnt_idx   = cand_idx;
        end
      end
    end
  end

  always_comb begin
    req_ready = '0;
    rom_addr  = '0;
    if (gnt_valid) begin
      req_ready[gnt_idx] = 1'b1;
      rom_addr           = req_addr[32'(gnt_idx) * ADDR_WIDTH +: ADDR_WIDTH];
    end
  end

  assign rom_rd_en = gnt_valid;

  always_comb begin
    rr_ptr_d      = rr_ptr_q;
    inflight_d    = inflight_q;
    inflight_id_d = inflight_id_q;
    resp_valid_d  = resp_valid_q;
    resp_id_d     = resp_id_q;
    resp_data_d   = resp_data_q;

    if (gnt_valid) begin
      rr_ptr_d      = gnt_idx;
      inflight_d    = 1'b1;
      inflight_id_d = gnt_idx;
    end else if (capture) begin
      inflight_d = 1'b0;
    end

    if (capture) begin
      resp_valid_d = 1'b1;
      resp_id_d    = inflight_id_q;
      resp_data_d  = rom_data;
    end else if (resp_valid_q && resp_ready) begin
      resp_valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rr_ptr_q      <= ID_WIDTH'(N_REQ - 1);
      inflight_q    <= 1'b0;
      inflight_id_q <= '0;
      resp_valid_q  <= 1'b0;
      resp_id_q     <= '0;
      resp_data_q   <= '0;
    end else begin
      rr_ptr_q      <= rr_ptr_d;
      inflight_q    <= inflight_d;
      inflight_id_q <= inflight_id_d;
      resp_valid_q  <= resp_valid_d;
      resp_id_q     <= resp_id_d;
      resp_data_q   <= resp_data_d;
    end
  end

  assign resp_valid = resp_valid_q;
  assign resp_id    = resp_id_q;
  assign resp_data  = resp_data_q;

endmodule
